data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Shares the single-port 16-bit data memory (4096 words, byte address, word index = addr[12:1], 1-cycle registered read) between two requesters.
- Port 0 is the CPU load/store stage; port 1 is the DMA/loader.
- Fixed priority to port 0, with a starvation guard that forces a port-1 grant after MAX_CONSEC consecutive port-0 wins while port 1 waits.
- Routes the memory's registered read data back to the owning port, and blocks out-of-range accesses.

Parameters:
- MAX_CONSEC, 4, consecutive port-0 grants allowed while req1 is pending before port 1 is forced (range 1..15)
- ADDR_LIMIT, 16'h2000, first illegal byte address (4096 words × 2 bytes)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req0  in  1  port 0 access request, held until gnt0
- we0  in  1  port 0 write (1) / read (0)
- addr0  in  16  port 0 byte address
- wdata0  in  16  port 0 write data
- gnt0  out  1  port 0 granted this cycle (combinational)
- rvalid0  out  1  port 0 read data valid (registered)
- rdata0  out  16  port 0 read data
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1
- err  out  1  sticky out-of-range flag, cleared only by reset
- mem_we  out  1  to memory control_write
- mem_addr  out  16  to memory addr
- mem_wdata  out  16  to memory write_data
- mem_rdata  in  16  from memory read_data

Behaviour:
- Reset: clk and async active-low rst_n, as fixed.
  - While rst_n=0: gnt0=gnt1=0, mem_we=0, rvalid0/1=0, rdata0/1=0, err=0, starve counter=0, owner register cleared.
  - After rst_n rises, the first grant can occur in the same cycle.
- Arbitration (combinational, each cycle):
  - force1 = req1 & (cnt == MAX_CONSEC).
  - gnt1 = req1 & (~req0 | force1).
  - gnt0 = req0 & ~gnt1.
  - At most one grant per cycle; no grant when neither port requests.
- Starve counter cnt (4 bits):
  - On gnt0 & req1: increment.
  - On gnt1, or when req1=0: clear to 0.
  - Otherwise: hold.
  - Never exceeds MAX_CONSEC.
- Memory drive:
  - mem_addr and mem_wdata are muxed from the granted port.
  - With no grant they hold port 0's inputs, and mem_we=0.
  - mem_we = grant & we_granted & in_range, where in_range = (addr_granted < ADDR_LIMIT).
- Writes:
  - Complete in the grant cycle; no rvalid.
  - Out-of-range write: suppressed, err set next edge, grant still issued (requester does not hang).
- Reads:
  - Grant in cycle N; the memory registers its data at edge N.
  - rvalidX=1 and rdataX=mem_rdata during cycle N+1.
  - The owner and in_range flags are registered at edge N to steer that data.
  - rdata of the owning port is registered/held at the last valid value otherwise.
  - Out-of-range read: rvalid still asserted at N+1 with rdata=16'h0000; err set.
- Back-to-back:
  - A new grant in cycle N+1 is allowed (full throughput, one access per cycle).
  - The return path depends only on the registered owner.
- Read-during-write to the same word by the other port in the same cycle is impossible, since only one grant is issued per cycle.
- Same-port read after write to the same address in the next cycle returns the new data.
- Requester rules:
  - Inputs must be stable while reqX=1 and gntX=0.
  - Dropping req before grant is legal: no access, and cnt clears if it was req1.
- Reset mid-read (grant at N, rst_n low before N+1): no rvalid is produced after reset release.

Decomposition:
- Shared package:
  - port index constants (PORT_CPU=0, PORT_DMA=1)
  - DMEM_WORDS=4096, DMEM_ADDR_LIMIT=16'h2000
  - a typedef for the request bundle (we, addr, wdata)
- Sub-module: none required.
  - Optional rr_starve_counter (cnt plus force1) if reused by the instruction-fetch arbiter.
- Otherwise flat, roughly 150 lines.

Test Plan:
1. Reset/idle: hold rst_n=0 with req0=req1=1 -> gnt0=gnt1=0, mem_we=0, rvalid0/1=0, err=0; release -> gnt0=1 that cycle.
2. Port-0 write then read: write 16'hBEEF to 16'h0010 (mem_we=1, mem_addr=16'h0010); read 16'h0010 next cycle -> rvalid0=1 one cycle later with rdata0=16'hBEEF; rvalid1 stays 0.
3. Starvation guard, MAX_CONSEC=4: req0 and req1 held high continuously -> gnt0 for 4 cycles, gnt1 on the 5th, then gnt0 resumes; cnt returns to 0.
4. Contention returns: port 0 reads 16'h0000 (holds 16'h1111) in cycle N, port 1 reads 16'h0002 (holds 16'h2222) in N+1 -> rdata0=16'h1111 with rvalid0 at N+1; rdata1=16'h2222 with rvalid1 at N+2.
5. Out of range: port 1 writes 16'h2000 -> mem_we=0, gnt1=1, err=1 next cycle. Port 0 reads 16'hFFFE -> rvalid0=1, rdata0=16'h0000. err stays 1 until rst_n low.
6. Reset mid-read: grant a port-0 read, assert rst_n low before the next edge -> rvalid0=0 throughout and after release, cnt=0.

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
// Purpose: shared constants and request bundle for the data-memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package data_mem_arbiter_pkg;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam int          DMEM_WORDS      = 4096;
  localparam logic [15:0] DMEM_ADDR_LIMIT = 16'h2000;

  // One requester's access, as seen by the memory mux.
  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/data_mem_arbiter_starve.sv
// Purpose: counts port-0 wins while port 1 waits and forces a port-1 grant at the limit.
// Latency: force1 is combinational from the registered count.
// Backpressure: none; the count clears whenever port 1 is served or stops asking.
module data_mem_arbiter_starve
  import data_mem_arbiter_pkg::*;
#(
  parameter int MAX_CONSEC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req1,
  input  logic gnt0,
  input  logic gnt1,
  output logic force1
);

  logic [3:0] cnt;

  assign force1 = req1 & (cnt == 4'(MAX_CONSEC));

  // Track how many times in a row port 1 has been passed over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (gnt1 || !req1) begin
      cnt <= '0;
    end else if (gnt0) begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Purpose: shares the single-port data memory between the CPU (port 0) and the DMA (port 1).
// Latency: grant and memory drive are combinational; read data returns one cycle after grant.
// Backpressure: requesters hold req until gnt; port 0 has priority, port 1 is forced after MAX_CONSEC losses.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int          MAX_CONSEC = 4,
  parameter logic [15:0] ADDR_LIMIT = DMEM_ADDR_LIMIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        we0,
  input  logic [15:0] addr0,
  input  logic [15:0] wdata0,
  output logic        gnt0,
  output logic        rvalid0,
  output logic [15:0] rdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata1,
  output logic        gnt1,
  output logic        rvalid1,
  output logic [15:0] rdata1,
  output logic        err,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  mem_req_t    req_p0;
  mem_req_t    req_p1;
  mem_req_t    req_sel;
  logic        req0_act;
  logic        req1_act;
  logic        force1;
  logic        any_gnt;
  logic        in_range;
  logic        rd_vld_q;
  logic        rd_owner_q;
  logic        rd_inr_q;
  logic [15:0] rd_dat;
  logic [15:0] rdata0_q;
  logic [15:0] rdata1_q;

  // Grants are held off while reset is asserted so nothing reaches the memory.
  assign req0_act = req0 & rst_n;
  assign req1_act = req1 & rst_n;

  data_mem_arbiter_starve #(
    .MAX_CONSEC(MAX_CONSEC)
  ) u_starve (
    .clk   (clk),
    .rst_n (rst_n),
    .req1  (req1_act),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .force1(force1)
  );

  assign gnt1    = req1_act & (~req0_act | force1);
  assign gnt0    = req0_act & ~gnt1;
  assign any_gnt = gnt0 | gnt1;

  // With no grant the mux rests on port 0; mem_we keeps the memory untouched.
  assign req_p0  = {we0, addr0, wdata0};
  assign req_p1  = {we1, addr1, wdata1};
  assign req_sel = gnt1 ? req_p1 : req_p0;

  assign in_range  = (req_sel.addr < ADDR_LIMIT);
  assign mem_we    = any_gnt & req_sel.we & in_range;
  assign mem_addr  = req_sel.addr;
  assign mem_wdata = req_sel.wdata;

  // Remember who issued this cycle's read so the next cycle's memory data can be steered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q   <= 1'b0;
      rd_owner_q <= PORT_CPU;
      rd_inr_q   <= 1'b0;
    end else begin
      rd_vld_q   <= any_gnt & ~req_sel.we;
      rd_owner_q <= gnt1 ? PORT_DMA : PORT_CPU;
      rd_inr_q   <= in_range;
    end
  end

  // Out-of-range reads still complete, but return zero rather than aliased memory.
  assign rd_dat  = rd_inr_q ? mem_rdata : 16'h0000;
  assign rvalid0 = rd_vld_q & (rd_owner_q == PORT_CPU);
  assign rvalid1 = rd_vld_q & (rd_owner_q == PORT_DMA);
  assign rdata0  = rvalid0 ? rd_dat : rdata0_q;
  assign rdata1  = rvalid1 ? rd_dat : rdata1_q;

  // Keep each port's last returned word visible between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0_q <= 16'h0000;
      rdata1_q <= 16'h0000;
    end else begin
      if (rvalid0) rdata0_q <= rd_dat;
      if (rvalid1) rdata1_q <= rd_dat;
    end
  end

  // Any granted out-of-range access latches the error until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (any_gnt && !in_range) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

  localparam int          MAXC  = 4;
  localparam logic [15:0] LIMIT = 16'h2000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, we0, req1, we1;
  logic [15:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err, mem_we;
  logic [15:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  data_mem_arbiter #(.MAX_CONSEC(MAXC), .ADDR_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .err(err), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Single-port memory with a registered read.
  logic [15:0] dmem [0:4095];
  always @(posedge clk) begin
    if (mem_we) dmem[mem_addr[12:1]] <= mem_wdata;
    mem_rdata <= dmem[mem_addr[12:1]];
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int          m_passed;
  logic        m_err;
  logic [15:0] m_hold0, m_hold1;
  logic [15:0] ref_mem [0:4095];

  logic        exp_gnt0, exp_gnt1, exp_mem_we, exp_rv0, exp_rv1, exp_err;
  logic [15:0] exp_mem_addr, exp_mem_wdata, exp_rd0, exp_rd1;
  logic        obs_gnt0, obs_gnt1, obs_mem_we, obs_rv0, obs_rv1, obs_err;
  logic [15:0] obs_mem_addr, obs_mem_wdata, obs_rd0, obs_rd1;

  task automatic model_reset();
    m_passed = 0;
    m_err    = 1'b0;
    m_hold0  = 16'h0000;
    m_hold1  = 16'h0000;
  endtask

  // Drives one cycle (entered at posedge+1), predicts it, and captures the DUT.
  task automatic run_cycle(input logic r0, input logic w0, input logic [15:0] a0, input logic [15:0] d0,
                           input logic r1, input logic w1, input logic [15:0] a1, input logic [15:0] d1);
    int          win;
    logic        gw, inr;
    logic [15:0] ga, gd, rd;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    // Port 1 wins if port 0 is idle or port 1 has already lost MAXC times in a row.
    if (r1 && (!r0 || m_passed == MAXC)) win = 1;
    else if (r0)                         win = 0;
    else                                 win = -1;
    gw  = (win == 1) ? w1 : w0;
    ga  = (win == 1) ? a1 : a0;
    gd  = (win == 1) ? d1 : d0;
    inr = (ga < LIMIT);
    exp_gnt0      = (win == 0);
    exp_gnt1      = (win == 1);
    exp_mem_we    = (win >= 0) && gw && inr;
    exp_mem_addr  = ga;
    exp_mem_wdata = gd;
    #3;
    obs_gnt0 = gnt0; obs_gnt1 = gnt1; obs_mem_we = mem_we;
    obs_mem_addr = mem_addr; obs_mem_wdata = mem_wdata;
    @(posedge clk);
    #1;
    m_passed = (win == 0 && r1) ? m_passed + 1 : 0;
    exp_rv0 = 1'b0;
    exp_rv1 = 1'b0;
    if (win >= 0 && !inr) m_err = 1'b1;
    if (win >= 0 && !gw) begin
      rd = inr ? ref_mem[ga[12:1]] : 16'h0000;
      if (win == 0) begin exp_rv0 = 1'b1; m_hold0 = rd; end
      else          begin exp_rv1 = 1'b1; m_hold1 = rd; end
    end
    if (exp_mem_we) ref_mem[ga[12:1]] = gd;
    exp_rd0 = m_hold0;
    exp_rd1 = m_hold1;
    exp_err = m_err;
    obs_rv0 = rvalid0; obs_rv1 = rvalid1; obs_rd0 = rdata0; obs_rd1 = rdata1; obs_err = err;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010; wdata0 = 16'h0000;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0012; wdata1 = 16'h0000;
    repeat (2) @(posedge clk);
    #4;
    n_checks++;
    if ({gnt0, gnt1, mem_we} !== 3'b000) begin
      n_fail++; $display("FAIL reset_grants: got %b want 000", {gnt0, gnt1, mem_we});
    end
    n_checks++;
    if ({rvalid0, rvalid1, err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000", {rvalid0, rvalid1, err});
    end
    n_checks++;
    if ({rdata0, rdata1} !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h want 0", {rdata0, rdata1});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    run_cycle(1'b1, 1'b1, 16'h0030, 16'hA5A5, 1'b1, 1'b1, 16'h0032, 16'h5A5A);
    n_checks++;
    if ({obs_gnt0, obs_gnt1} !== 2'b10) begin
      n_fail++; $display("FAIL release_gnt0: got %b want 10", {obs_gnt0, obs_gnt1});
    end
    run_cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0032, 16'h5A5A);
    n_checks++;
    if ({obs_gnt0, obs_gnt1} !== 2'b01) begin
      n_fail++; $display("FAIL release_gnt1: got %b want 01", {obs_gnt0, obs_gnt1});
    end
  endtask

  task automatic test_write_read();
    run_cycle(1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 16'h0000);
    n_checks++;
    if ({obs_gnt0, obs_mem_we, obs_mem_addr, obs_mem_wdata} !== {2'b11, 16'h0010, 16'hBEEF}) begin
      n_fail++; $display("FAIL wr_drive: got %b%b %h %h want 11 0010 beef",
                         obs_gnt0, obs_mem_we, obs_mem_addr, obs_mem_wdata);
    end
    run_cycle(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    n_checks++;
    if ({obs_rv0, obs_rv1, obs_rd0} !== {2'b10, 16'hBEEF}) begin
      n_fail++; $display("FAIL rd_return: got rv=%b%b rd0=%h want 10 beef", obs_rv0, obs_rv1, obs_rd0);
    end
    run_cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    n_checks++;
    if ({obs_rv0, obs_rd0} !== {1'b0, 16'hBEEF}) begin
      n_fail++; $display("FAIL rd_hold: got rv0=%b rd0=%h want 0 beef", obs_rv0, obs_rd0);
    end
  endtask

  task automatic test_starvation();
    for (int i = 0; i < 10; i++) begin
      logic want1;
      want1 = (i == 4) || (i == 9);
      run_cycle(1'b1, 1'b1, 16'h0040, 16'(i), 1'b1, 1'b1, 16'h0042, 16'h5555);
      n_checks++;
      if ({obs_gnt0, obs_gnt1} !== {~want1, want1}) begin
        n_fail++; $display("FAIL starve_cycle%0d: got %b want %b", i, {obs_gnt0, obs_gnt1}, {~want1, want1});
      end
    end
  endtask

  task automatic test_contention();
    run_cycle(1'b1, 1'b1, 16'h0000, 16'h1111, 1'b0, 1'b0, 16'h0000, 16'h0000);
    run_cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0002, 16'h2222);
    run_cycle(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0002, 16'h0000);
    n_checks++;
    if ({obs_gnt0, obs_rv0, obs_rv1, obs_rd0} !== {3'b110, 16'h1111}) begin
      n_fail++; $display("FAIL cont_p0: got g0=%b rv=%b%b rd0=%h want 1 10 1111",
                         obs_gnt0, obs_rv0, obs_rv1, obs_rd0);
    end
    run_cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0002, 16'h0000);
    n_checks++;
    if ({obs_gnt1, obs_rv0, obs_rv1, obs_rd1, obs_rd0} !== {3'b101, 16'h2222, 16'h1111}) begin
      n_fail++; $display("FAIL cont_p1: got g1=%b rv=%b%b rd1=%h rd0=%h want 1 01 2222 1111",
                         obs_gnt1, obs_rv0, obs_rv1, obs_rd1, obs_rd0);
    end
  endtask

  task automatic test_out_of_range();
    run_cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h2000, 16'hDEAD);
    n_checks++;
    if ({obs_gnt1, obs_mem_we, obs_err} !== 3'b101) begin
      n_fail++; $display("FAIL oor_write: got g1/we/err=%b want 101", {obs_gnt1, obs_mem_we, obs_err});
    end
    run_cycle(1'b1, 1'b0, 16'hFFFE, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    n_checks++;
    if ({obs_gnt0, obs_rv0, obs_rd0, obs_err} !== {2'b11, 16'h0000, 1'b1}) begin
      n_fail++; $display("FAIL oor_read: got g0=%b rv0=%b rd0=%h err=%b want 1 1 0000 1",
                         obs_gnt0, obs_rv0, obs_rd0, obs_err);
    end
    for (int i = 0; i < 3; i++) begin
      run_cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
      n_checks++;
      if (obs_err !== 1'b1) begin
        n_fail++; $display("FAIL err_sticky%0d: got %b want 1", i, obs_err);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010; wdata0 = 16'h0000;
    req1 = 1'b0; we1 = 1'b0; addr1 = 16'h0000; wdata1 = 16'h0000;
    #3;
    n_checks++;
    if (gnt0 !== 1'b1) begin
      n_fail++; $display("FAIL midrd_grant: got %b want 1", gnt0);
    end
    #5;
    rst_n = 1'b0;
    req0  = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({rvalid0, err} !== 2'b00) begin
      n_fail++; $display("FAIL midrd_in_reset: got rv0/err=%b want 00", {rvalid0, err});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    run_cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    n_checks++;
    if ({obs_rv0, obs_rd0, obs_err} !== {1'b0, 16'h0000, 1'b0}) begin
      n_fail++; $display("FAIL midrd_after: got rv0=%b rd0=%h err=%b want 0 0000 0", obs_rv0, obs_rd0, obs_err);
    end
    for (int i = 0; i < 5; i++) begin
      run_cycle(1'b1, 1'b1, 16'h0050, 16'h0001, 1'b1, 1'b1, 16'h0052, 16'h0002);
      n_checks++;
      if (obs_gnt1 !== (i == 4)) begin
        n_fail++; $display("FAIL midrd_cnt%0d: got gnt1=%b want %b", i, obs_gnt1, (i == 4));
      end
    end
  endtask

  task automatic test_random();
    logic        p0, p1, r0, w0, r1, w1;
    logic [15:0] a0, d0, a1, d1;
    for (int w = 0; w < 16; w++)
      run_cycle(1'b1, 1'b1, 16'(w * 2), 16'($urandom), 1'b0, 1'b0, 16'h0000, 16'h0000);
    p0 = 1'b0; p1 = 1'b0;
    r0 = 1'b0; w0 = 1'b0; a0 = 16'h0; d0 = 16'h0;
    r1 = 1'b0; w1 = 1'b0; a1 = 16'h0; d1 = 16'h0;
    for (int i = 0; i < 400; i++) begin
      // A waiting request keeps its inputs, or is occasionally withdrawn for a cycle.
      if (p0) begin
        if ($urandom_range(0, 7) == 0) r0 = 1'b0;
      end else begin
        r0 = ($urandom_range(0, 3) != 0);
        w0 = 1'($urandom_range(0, 1));
        a0 = ($urandom_range(0, 15) == 0) ? 16'(32'h2000 + $urandom_range(0, 100) * 2)
                                          : 16'($urandom_range(0, 15) * 2);
        d0 = 16'($urandom);
      end
      if (p1) begin
        if ($urandom_range(0, 7) == 0) r1 = 1'b0;
      end else begin
        r1 = ($urandom_range(0, 2) != 0);
        w1 = 1'($urandom_range(0, 1));
        a1 = ($urandom_range(0, 15) == 0) ? 16'(32'h2000 + $urandom_range(0, 100) * 2)
                                          : 16'($urandom_range(0, 15) * 2);
        d1 = 16'($urandom);
      end
      run_cycle(r0, w0, a0, d0, r1, w1, a1, d1);
      p0 = r0 && !exp_gnt0;
      p1 = r1 && !exp_gnt1;
      n_checks++;
      if ({obs_gnt0, obs_gnt1, obs_mem_we, obs_mem_addr, obs_mem_wdata} !==
          {exp_gnt0, exp_gnt1, exp_mem_we, exp_mem_addr, exp_mem_wdata}) begin
        n_fail++; $display("FAIL rand_drive%0d: got %b%b%b %h %h want %b%b%b %h %h", i,
                           obs_gnt0, obs_gnt1, obs_mem_we, obs_mem_addr, obs_mem_wdata,
                           exp_gnt0, exp_gnt1, exp_mem_we, exp_mem_addr, exp_mem_wdata);
      end
      n_checks++;
      if ({obs_rv0, obs_rv1, obs_rd0, obs_rd1, obs_err} !==
          {exp_rv0, exp_rv1, exp_rd0, exp_rd1, exp_err}) begin
        n_fail++; $display("FAIL rand_return%0d: got %b%b %h %h %b want %b%b %h %h %b", i,
                           obs_rv0, obs_rv1, obs_rd0, obs_rd1, obs_err,
                           exp_rv0, exp_rv1, exp_rd0, exp_rd1, exp_err);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write_read();
    test_starvation();
    test_contention();
    test_out_of_range();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
